// File: rtl/tdm_demux.sv
// Time-division demultiplexer: splits a round-robin interleaved serial stream into NCH words.
// Define TDM_DEMUX_PARITY_EN to add a trailing even-parity frame per word and a parity_err output.
module tdm_demux #(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  input  logic                 in_valid,
  input  logic                 frame_sync,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  output logic [SELW-1:0]      sel,
  output logic                 locked,
  output logic                 sync_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic [NCH-1:0]       parity_err
`endif
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAMES = WIDTH + 1;
`else
  localparam int FRAMES = WIDTH;
`endif
  localparam int BCW = $clog2(FRAMES);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [SELW-1:0]     r_sel;
  logic [BCW-1:0]      r_bitcnt;
  logic [FRAMES-1:0]   r_shift [NCH];
  logic [WIDTH-1:0]    r_data  [NCH];
  logic [NCH-1:0]      r_out_valid;
  logic                r_sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic [NCH-1:0]      r_parity_err;
`endif

  logic                w_sync_seen;
  logic                w_misplaced;
  logic                w_restart;
  logic                w_shift_now;
  logic                w_last;
  logic [FRAMES-1:0]   w_word;

  assign w_sync_seen = in_valid && frame_sync;
  assign w_misplaced = (r_state == LOCK) && w_sync_seen &&
                       ((r_sel != '0) || (r_bitcnt != '0));
  assign w_restart   = ((r_state == HUNT) && w_sync_seen) || w_misplaced;
  assign w_shift_now = (r_state == LOCK) && in_valid && !w_misplaced;
  assign w_last      = (r_bitcnt == BCW'(FRAMES - 1));
  assign w_word      = {r_shift[r_sel][FRAMES-2:0], in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HUNT:    if (w_sync_seen) w_state_next = LOCK;
      LOCK:    w_state_next = LOCK;
      default: w_state_next = HUNT;
    endcase
  end

  // A restart (first sync or misplaced sync) drops every partial word and seeds channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= '0;
      r_bitcnt    <= '0;
      r_out_valid <= '0;
      r_sync_err  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_shift[k] <= '0;
        r_data[k]  <= '0;
      end
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err <= '0;
`endif
    end else begin
      r_out_valid <= '0;
      r_sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err <= '0;
`endif
      if (w_restart) begin
        for (int k = 0; k < NCH; k++) r_shift[k] <= '0;
        r_shift[0] <= {{(FRAMES-1){1'b0}}, in};
        r_sel      <= SELW'(1);
        r_bitcnt   <= '0;
        r_sync_err <= w_misplaced;
      end else if (w_shift_now) begin
        r_shift[r_sel] <= w_word;
        r_sel          <= r_sel + 1'b1;
        if (r_sel == SELW'(NCH - 1))
          r_bitcnt <= w_last ? '0 : r_bitcnt + 1'b1;
        if (w_last) begin
          r_data[r_sel]      <= w_word[FRAMES-1 -: WIDTH];
          r_out_valid[r_sel] <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
          r_parity_err[r_sel] <= ^w_word;
`endif
        end
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign out_data[k*WIDTH +: WIDTH] = r_data[k];
  end

  assign out_valid = r_out_valid;
  assign sel       = r_sel;
  assign locked    = (r_state == LOCK);
  assign sync_err  = r_sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule
